cmd_issue_ctrl: RTL

Command-issue controller that sits in front of the SD CMD-line transmitter and sequences every command on the bus. It arbitrates between host-issued commands and Auto CMD12 requests from the data path, and enforces the minimum command-to-command gap (NCC). It drives the transmitter's start/argument/index inputs, tracks transmission completion and opens a bounded response window for the response receiver. All sequencing runs on the SD-clock positive-edge enable; the result is a single completion or timeout event per command.

---
 rtl/cmd_issue_ctrl_if.sv | 26 ++
 rtl/cmd_issue_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cmd_issue_ctrl_if.sv
// cmd_issue_ctrl_if: host and Auto CMD12 request/grant handshakes
// into the command-issue controller.
`timescale 1ns/1ps
interface cmd_issue_ctrl_if;
  logic        host_req_i;
  logic [5:0]  host_cmd_nr_i;
  logic [31:0] host_arg_i;
  logic        host_resp_i;
  logic        host_ack_o;
  logic        auto12_req_i;
  logic        auto12_ack_o;

  modport master (
    output host_req_i, host_cmd_nr_i,
    output host_arg_i, host_resp_i,
    output auto12_req_i,
    input  host_ack_o, auto12_ack_o
  );

  modport slave (
    input  host_req_i, host_cmd_nr_i,
    input  host_arg_i, host_resp_i,
    input  auto12_req_i,
    output host_ack_o, auto12_ack_o
  );
endinterface

// File: rtl/cmd_issue_ctrl.sv
// cmd_issue_ctrl: SD CMD-line issue sequencer with NCC gap and NCR window.
// CMD_ISSUE_AUTO12_EN enables the Auto CMD12 request path.
`timescale 1ns/1ps
module cmd_issue_ctrl #(
  parameter int unsigned NccCycles   = 8,
  parameter int unsigned RespTimeout = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clk_en_p_i,
  cmd_issue_ctrl_if.slave bus,
  output logic            start_tx_o,
  output logic [5:0]      cmd_nr_o,
  output logic [31:0]     cmd_argument_o,
  input  logic            tx_done_i,
  output logic            resp_en_o,
  input  logic            resp_done_i,
  output logic            cmd_complete_o,
  output logic            resp_timeout_o,
  output logic            cmd_src_o,
  output logic            cmd_inhibit_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    TX_WAIT,
    RESP_WAIT
  } state_e;

  localparam logic [7:0] Ncc  = 8'(NccCycles);
  localparam logic [7:0] Term = 8'(RespTimeout - 1);

  state_e      state_q, state_d;
  logic [7:0]  gap_q, gap_d;
  logic [7:0]  win_q, win_d;
  logic [5:0]  nr_q;
  logic [31:0] arg_q;
  logic        resp_q;
  logic        a12_req;
  logic        ack_host, ack_a12;
  logic        cmp, tout;
  logic        can_grant;

`ifdef CMD_ISSUE_AUTO12_EN
  logic src_q;
  assign a12_req   = bus.auto12_req_i;
  assign cmd_src_o = src_q;
`else
  logic unused_a12;
  assign unused_a12 = bus.auto12_req_i;
  assign a12_req    = 1'b0;
  assign cmd_src_o  = 1'b0;
`endif

  // grants are gated by rst_ni so no ack escapes while held in reset
  assign can_grant = rst_ni && clk_en_p_i
                  && (state_q == IDLE)
                  && (gap_q == '0);

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    win_d    = win_q;
    ack_host = 1'b0;
    ack_a12  = 1'b0;
    cmp      = 1'b0;
    tout     = 1'b0;
    if (clk_en_p_i && gap_q != '0)
      gap_d = gap_q - 8'd1;
    unique case (state_q)
      IDLE: begin
        if (can_grant) begin
          if (a12_req) begin
            ack_a12 = 1'b1;
            state_d = ISSUE;
          end else if (bus.host_req_i) begin
            ack_host = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (clk_en_p_i && !tx_done_i)
          state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (clk_en_p_i && tx_done_i) begin
          if (resp_q) begin
            state_d = RESP_WAIT;
            win_d   = '0;
          end else begin
            cmp     = 1'b1;
            state_d = IDLE;
            gap_d   = Ncc;
          end
        end
      end
      RESP_WAIT: begin
        if (clk_en_p_i) begin
          if (resp_done_i) begin
            cmp     = 1'b1;
            state_d = IDLE;
            gap_d   = Ncc;
          end else if (win_q == Term) begin
            tout    = 1'b1;
            state_d = IDLE;
            gap_d   = Ncc;
          end else begin
            win_d = win_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gap_q   <= '0;
      win_q   <= '0;
      nr_q    <= '0;
      arg_q   <= '0;
      resp_q  <= 1'b0;
`ifdef CMD_ISSUE_AUTO12_EN
      src_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      win_q   <= win_d;
      if (ack_a12) begin
        nr_q   <= 6'd12;
        arg_q  <= '0;
        resp_q <= 1'b1;
`ifdef CMD_ISSUE_AUTO12_EN
        src_q  <= 1'b1;
`endif
      end else if (ack_host) begin
        nr_q   <= bus.host_cmd_nr_i;
        arg_q  <= bus.host_arg_i;
        resp_q <= bus.host_resp_i;
`ifdef CMD_ISSUE_AUTO12_EN
        src_q  <= 1'b0;
`endif
      end
    end
  end

  assign bus.host_ack_o   = ack_host;
  assign bus.auto12_ack_o = ack_a12;
  assign start_tx_o       = (state_q == ISSUE);
  assign resp_en_o        = (state_q == RESP_WAIT);
  assign cmd_nr_o         = nr_q;
  assign cmd_argument_o   = arg_q;
  assign cmd_complete_o   = cmp;
  assign resp_timeout_o   = tout;
  assign cmd_inhibit_o    = (state_q != IDLE)
                         || (gap_q != '0);

endmodule
